seg7_frame_decoder: RTL and testbench

Read-back decoder for the multiplexed 7-segment display bus. It synchronizes and debounces the active-low anode and segment lines and decodes each digit's segment pattern back to a BCD value. It assembles the decoded values into a 4-digit frame and pulses a valid strobe per complete frame. It sits beside the display driver and gives self-check logic and the step-count display a way to confirm what the panel actually shows.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_pattern_decode.sv | 32 +++
 rtl/seg7_frame_decoder.sv | 177 +++++++++++++++++
 tb/tb_seg7_frame_decoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low patterns {a,b,c,d,e,f,g}, MSB = a,
// plus the read-back decoder FSM state type.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0001100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] DIGIT_INVALID = 4'hF;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_EMIT    = 2'd2
   } seg7_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from an active-low segment pattern to its BCD value.
// Unrecognised patterns return DIGIT_INVALID with valid low.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic       valid,
   output logic [3:0] value
);

   always_comb begin
      valid = 1'b1;
      value = DIGIT_INVALID;
      case (seg_n)
         SEG_0:   value = 4'd0;
         SEG_1:   value = 4'd1;
         SEG_2:   value = 4'd2;
         SEG_3:   value = 4'd3;
         SEG_4:   value = 4'd4;
         SEG_5:   value = 4'd5;
         SEG_6:   value = 4'd6;
         SEG_7:   value = 4'd7;
         SEG_8:   value = 4'd8;
         SEG_9:   value = 4'd9;
         default: begin
            valid = 1'b0;
            value = DIGIT_INVALID;
         end
      endcase
   end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Read-back decoder for the multiplexed 7-segment bus: synchronize, settle,
// sample once per dwell, decode, and assemble digits into complete frames.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_HUNT    | waiting for a digit-0 sample to start a frame
// ST_COLLECT | digits 0..exp-1 staged, waiting for digit exp
// ST_EMIT    | one cycle: publish staged frame and pulse frame_valid
module seg7_frame_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int SETTLE_CYCLES = 4
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   an_n,
   output logic [4*NUM_DIGITS-1:0] frame_digits,
   output logic                    frame_valid,
   output logic                    frame_bad,
   output logic                    sync_err
);

   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int WW = NUM_DIGITS + 7;

   localparam logic [CW-1:0] CNT_SAT    = CW'(SETTLE_CYCLES);
   localparam logic [CW-1:0] CNT_SAMPLE = CW'(SETTLE_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   logic [WW-1:0]           sync1, sync2;
   logic [CW-1:0]           cnt;
   logic [NUM_DIGITS-1:0]   an_s, an_act;
   logic [6:0]              seg_s;
   logic                    sample, is_blank, is_single, is_multi;
   logic [IW-1:0]           idx;
   logic                    dec_valid;
   logic [3:0]              dec_value;

   seg7_state_t             state_q, state_d;
   logic [IW-1:0]           exp_q, exp_d;
   logic [4*NUM_DIGITS-1:0] stage_q, stage_d;
   logic                    bad_q, bad_d;
   logic [4*NUM_DIGITS-1:0] frame_digits_d;
   logic                    frame_valid_d, frame_bad_d, sync_err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= {an_n, seg_n};
         sync2 <= sync1;
      end
   end

   assign an_s  = sync2[WW-1:7];
   assign seg_s = sync2[6:0];

   // Clearing on sync1 != sync2 zeroes the count on the very cycle a new word
   // lands on sync2, so a dwell is counted from its first synchronized cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (sync1 != sync2) begin
         cnt <= '0;
      end else if (cnt != CNT_SAT) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign sample    = (cnt == CNT_SAMPLE);
   assign an_act    = ~an_s;
   assign is_blank  = (an_act == '0);
   assign is_single = $onehot(an_act);
   assign is_multi  = !is_blank && !is_single;

   always_comb begin
      idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (an_act[i]) idx = IW'(i);
      end
   end

   seg7_pattern_decode u_decode (
      .seg_n (seg_s),
      .valid (dec_valid),
      .value (dec_value)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_HUNT;
         exp_q        <= '0;
         stage_q      <= '0;
         bad_q        <= 1'b0;
         frame_digits <= '0;
         frame_valid  <= 1'b0;
         frame_bad    <= 1'b0;
         sync_err     <= 1'b0;
      end else begin
         state_q      <= state_d;
         exp_q        <= exp_d;
         stage_q      <= stage_d;
         bad_q        <= bad_d;
         frame_digits <= frame_digits_d;
         frame_valid  <= frame_valid_d;
         frame_bad    <= frame_bad_d;
         sync_err     <= sync_err_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      exp_d          = exp_q;
      stage_d        = stage_q;
      bad_d          = bad_q;
      frame_digits_d = frame_digits;
      frame_valid_d  = 1'b0;
      frame_bad_d    = frame_bad;
      sync_err_d     = 1'b0;

      case (state_q)
         ST_HUNT: begin
            if (sample && is_multi) begin
               sync_err_d = 1'b1;
            end else if (sample && is_single && idx == '0) begin
               stage_d[3:0] = dec_value;
               bad_d        = !dec_valid;
               exp_d        = IW'(1);
               state_d      = ST_COLLECT;
            end
         end

         ST_COLLECT: begin
            if (sample && is_multi) begin
               sync_err_d = 1'b1;
               exp_d      = '0;
               state_d    = ST_HUNT;
            end else if (sample && is_single) begin
               if (idx == exp_q) begin
                  stage_d[4*int'(idx) +: 4] = dec_value;
                  if (!dec_valid) bad_d = 1'b1;
                  exp_d = exp_q + IW'(1);
                  if (idx == IDX_LAST) state_d = ST_EMIT;
               end else begin
                  sync_err_d = 1'b1;
                  if (idx == '0) begin
                     stage_d[3:0] = dec_value;
                     bad_d        = !dec_valid;
                     exp_d        = IW'(1);
                  end else begin
                     exp_d   = '0;
                     state_d = ST_HUNT;
                  end
               end
            end
         end

         ST_EMIT: begin
            frame_digits_d = stage_q;
            frame_bad_d    = bad_q;
            frame_valid_d  = 1'b1;
            exp_d          = '0;
            state_d        = ST_HUNT;
         end

         default: begin
            exp_d   = '0;
            state_d = ST_HUNT;
         end
      endcase
   end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed bench for seg7_frame_decoder: scans digits over the display bus and
// checks emitted frames, bad flags, sync errors and reset behaviour.
module tb_seg7_frame_decoder;

   logic        clk;
   logic        rst_n;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic [15:0] frame_digits;
   logic        frame_valid;
   logic        frame_bad;
   logic        sync_err;

   int checks = 0;
   int passed = 0;

   int          fv_cnt  = 0;
   int          se_cnt  = 0;
   int          dbl_cnt = 0;
   logic        fv_prev = 1'b0;
   logic [15:0] cap_digits = '0;
   logic        cap_bad = 1'b0;
   int          fv0, se0;

   seg7_frame_decoder #(.NUM_DIGITS(4), .SETTLE_CYCLES(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .seg_n        (seg_n),
      .an_n         (an_n),
      .frame_digits (frame_digits),
      .frame_valid  (frame_valid),
      .frame_bad    (frame_bad),
      .sync_err     (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_valid) begin
            fv_cnt++;
            cap_digits = frame_digits;
            cap_bad    = frame_bad;
         end
         if (frame_valid && fv_prev) dbl_cnt++;
         if (sync_err) se_cnt++;
         fv_prev = frame_valid;
      end else begin
         fv_prev = 1'b0;
      end
   end

   function automatic logic [6:0] pat(input int v);
      case (v)
         0: pat = 7'b0000001;
         1: pat = 7'b1001111;
         2: pat = 7'b0010010;
         3: pat = 7'b0000110;
         4: pat = 7'b1001100;
         5: pat = 7'b0100100;
         6: pat = 7'b0100000;
         7: pat = 7'b0001111;
         8: pat = 7'b0000000;
         9: pat = 7'b0001100;
         default: pat = 7'b1111111;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
      an_n  = an;
      seg_n = seg;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
      drive(4'b1110, s0, 8);
      drive(4'b1101, s1, 8);
      drive(4'b1011, s2, 8);
      drive(4'b0111, s3, 8);
      drive(4'b1111, 7'b1111111, 6);
   endtask

   initial begin
      rst_n = 1'b0;
      an_n  = 4'b1111;
      seg_n = 7'b1111111;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_digits", 32'(frame_digits), 32'h0);
      chk("reset_valid",  32'(frame_valid),  32'h0);
      chk("reset_bad",    32'(frame_bad),    32'h0);
      chk("reset_syncerr", 32'(sync_err),    32'h0);
      rst_n = 1'b1;
      drive(4'b1111, 7'b1111111, 6);

      // clean scan 1,2,3,4
      fv0 = fv_cnt; se0 = se_cnt;
      scan4(pat(1), pat(2), pat(3), pat(4));
      chk("scan1_valid_cnt", 32'(fv_cnt - fv0), 32'd1);
      chk("scan1_digits",    32'(cap_digits),   32'h4321);
      chk("scan1_bad",       32'(cap_bad),      32'h0);
      chk("scan1_syncerr",   32'(se_cnt - se0), 32'd0);

      // undecodable pattern on digit 2
      fv0 = fv_cnt;
      scan4(pat(1), pat(2), 7'b1111110, pat(4));
      chk("bad_valid_cnt", 32'(fv_cnt - fv0), 32'd1);
      chk("bad_digits",    32'(cap_digits),   32'h4F21);
      chk("bad_flag",      32'(cap_bad),      32'h1);
      chk("bad_out_held",  32'(frame_bad),    32'h1);

      // glitch: digit 1 shows 9 for SETTLE_CYCLES-1 cycles before settling on 6
      fv0 = fv_cnt; se0 = se_cnt;
      drive(4'b1110, pat(5), 8);
      drive(4'b1101, pat(9), 3);
      drive(4'b1101, pat(6), 8);
      drive(4'b1011, pat(7), 8);
      drive(4'b0111, pat(8), 8);
      drive(4'b1111, 7'b1111111, 6);
      chk("glitch_valid_cnt", 32'(fv_cnt - fv0), 32'd1);
      chk("glitch_digits",    32'(cap_digits),   32'h8765);
      chk("glitch_bad",       32'(cap_bad),      32'h0);
      chk("glitch_syncerr",   32'(se_cnt - se0), 32'd0);

      // order violation 0,1,3
      fv0 = fv_cnt; se0 = se_cnt;
      drive(4'b1110, pat(1), 8);
      drive(4'b1101, pat(1), 8);
      drive(4'b0111, pat(1), 8);
      drive(4'b1111, 7'b1111111, 6);
      chk("order_syncerr",   32'(se_cnt - se0),  32'd1);
      chk("order_valid_cnt", 32'(fv_cnt - fv0),  32'd0);
      chk("order_digits",    32'(frame_digits),  32'h8765);
      fv0 = fv_cnt;
      scan4(pat(9), pat(0), pat(1), pat(2));
      chk("recover_valid_cnt", 32'(fv_cnt - fv0), 32'd1);
      chk("recover_digits",    32'(cap_digits),   32'h2109);

      // multi-anode sample mid-frame, then digits 1..3 must be ignored in HUNT
      fv0 = fv_cnt; se0 = se_cnt;
      drive(4'b1110, pat(3), 8);
      drive(4'b1100, pat(8), 8);
      drive(4'b1101, pat(4), 8);
      drive(4'b1011, pat(5), 8);
      drive(4'b0111, pat(6), 8);
      drive(4'b1111, 7'b1111111, 6);
      chk("multi_syncerr",   32'(se_cnt - se0), 32'd1);
      chk("multi_valid_cnt", 32'(fv_cnt - fv0), 32'd0);
      chk("multi_digits",    32'(frame_digits), 32'h2109);

      // reset after digit 2 of a scan
      fv0 = fv_cnt;
      drive(4'b1110, pat(5), 8);
      drive(4'b1101, pat(5), 8);
      drive(4'b1011, pat(5), 8);
      rst_n = 1'b0;
      #1;
      chk("midrst_digits",  32'(frame_digits), 32'h0);
      chk("midrst_valid",   32'(frame_valid),  32'h0);
      chk("midrst_bad",     32'(frame_bad),    32'h0);
      chk("midrst_syncerr", 32'(sync_err),     32'h0);
      drive(4'b0111, pat(5), 3);
      rst_n = 1'b1;
      drive(4'b1111, 7'b1111111, 8);
      chk("midrst_no_valid", 32'(fv_cnt - fv0), 32'd0);
      scan4(pat(7), pat(3), pat(9), pat(0));
      chk("postrst_valid_cnt", 32'(fv_cnt - fv0), 32'd1);
      chk("postrst_digits",    32'(cap_digits),   32'h0937);
      chk("postrst_bad",       32'(cap_bad),      32'h0);

      chk("valid_never_double", 32'(dbl_cnt), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
